// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter funnelling NUM_M simple AXI masters onto one external AXI4 port
// and one local AXI-lite read port, with one transaction outstanding at a time.
module axi_rr_arbiter #(
    parameter int          NUM_M      = 2,
    parameter int          DW         = 32,
    parameter logic [31:0] LOCAL_BASE = 32'h0200_0000,
    parameter logic [31:0] LOCAL_MASK = 32'hFFFF_0000
) (
    input  logic                      clock,
    input  logic                      reset,
    // upstream masters, master i in slice i
    input  logic [NUM_M*32-1:0]       m_araddr,
    input  logic [NUM_M*3-1:0]        m_arsize,
    input  logic [NUM_M-1:0]          m_arvalid,
    output logic [NUM_M-1:0]          m_arready,
    output logic [NUM_M*DW-1:0]       m_rdata,
    output logic [NUM_M*2-1:0]        m_rresp,
    output logic [NUM_M-1:0]          m_rvalid,
    input  logic [NUM_M-1:0]          m_rready,
    input  logic [NUM_M*32-1:0]       m_awaddr,
    input  logic [NUM_M*3-1:0]        m_awsize,
    input  logic [NUM_M-1:0]          m_awvalid,
    output logic [NUM_M-1:0]          m_awready,
    input  logic [NUM_M*DW-1:0]       m_wdata,
    input  logic [NUM_M*(DW/8)-1:0]   m_wstrb,
    input  logic [NUM_M-1:0]          m_wvalid,
    output logic [NUM_M-1:0]          m_wready,
    output logic [NUM_M*2-1:0]        m_bresp,
    output logic [NUM_M-1:0]          m_bvalid,
    input  logic [NUM_M-1:0]          m_bready,
    // external AXI4 slave
    output logic [3:0]                ext_arid,
    output logic [31:0]               ext_araddr,
    output logic [7:0]                ext_arlen,
    output logic [2:0]                ext_arsize,
    output logic [1:0]                ext_arburst,
    output logic                      ext_arvalid,
    input  logic                      ext_arready,
    input  logic [DW-1:0]             ext_rdata,
    input  logic [1:0]                ext_rresp,
    input  logic                      ext_rvalid,
    output logic                      ext_rready,
    output logic [3:0]                ext_awid,
    output logic [31:0]               ext_awaddr,
    output logic [7:0]                ext_awlen,
    output logic [2:0]                ext_awsize,
    output logic [1:0]                ext_awburst,
    output logic                      ext_awvalid,
    input  logic                      ext_awready,
    output logic [DW-1:0]             ext_wdata,
    output logic [DW/8-1:0]           ext_wstrb,
    output logic                      ext_wlast,
    output logic                      ext_wvalid,
    input  logic                      ext_wready,
    input  logic [1:0]                ext_bresp,
    input  logic                      ext_bvalid,
    output logic                      ext_bready,
    // local read-only slave
    output logic [31:0]               loc_araddr,
    output logic                      loc_arvalid,
    input  logic                      loc_arready,
    input  logic [DW-1:0]             loc_rdata,
    input  logic [1:0]                loc_rresp,
    input  logic                      loc_rvalid,
    output logic                      loc_rready,
    // status
    output logic [$clog2(NUM_M)-1:0]  grant,
    output logic                      busy
);

    localparam int GW = $clog2(NUM_M);
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

    state_t          state_r, state_next_s;
    logic [GW-1:0]   owner_r, rr_ptr_r, win_s;
    logic            local_r, busy_r;
    logic            ar_done_r, aw_done_r, w_done_r;
    logic            loc_aw_rdy_r, loc_w_rdy_r, loc_bvalid_r;

    logic [NUM_M-1:0] req_s;
    logic             found_s, win_rd_s, win_local_s;
    logic [31:0]      win_addr_s;
    int               win_i_s, own_i_s;

    logic [31:0]      own_araddr_s, own_awaddr_s;
    logic [2:0]       own_arsize_s, own_awsize_s;
    logic             own_arvalid_s, own_rready_s, own_awvalid_s, own_wvalid_s, own_bready_s;
    logic [DW-1:0]    own_wdata_s;
    logic [SW-1:0]    own_wstrb_s;

    logic             sel_arready_s, sel_rvalid_s, sel_awready_s, sel_wready_s, sel_bvalid_s;
    logic [DW-1:0]    sel_rdata_s;
    logic [1:0]       sel_rresp_s, sel_bresp_s;
    logic             ar_hs_s, aw_hs_s, w_hs_s, done_s, local_wr_s;

    assign req_s      = m_arvalid | m_awvalid;
    assign local_wr_s = (state_r == WR) & local_r;
    assign ar_hs_s    = own_arvalid_s & sel_arready_s;
    assign aw_hs_s    = own_awvalid_s & sel_awready_s;
    assign w_hs_s     = own_wvalid_s & sel_wready_s;
    assign done_s     = ((state_r == RD) & sel_rvalid_s & own_rready_s) |
                        ((state_r == WR) & sel_bvalid_s & own_bready_s);

    assign grant       = owner_r;
    assign busy        = busy_r;
    assign ext_arid    = 4'd0;
    assign ext_arlen   = 8'd0;
    assign ext_arburst = 2'b01;
    assign ext_awid    = 4'd0;
    assign ext_awlen   = 8'd0;
    assign ext_awburst = 2'b01;

    // Round-robin search, starting just after the last completed owner
    always_comb begin
        found_s = 1'b0;
        win_s   = {GW{1'b0}};
        for (int k = 1; k <= NUM_M; k++) begin
            int idx;
            idx = (int'(rr_ptr_r) + k) % NUM_M;
            if (!found_s && req_s[idx]) begin
                found_s = 1'b1;
                win_s   = idx[GW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Winner's direction (read wins ties) and address decode
    always_comb begin
        win_i_s     = int'(win_s);
        win_rd_s    = m_arvalid[win_s];
        win_addr_s  = win_rd_s ? m_araddr[win_i_s*32 +: 32] : m_awaddr[win_i_s*32 +: 32];
        win_local_s = ((win_addr_s & LOCAL_MASK) == LOCAL_BASE);
    end

    // Owning master's request fields
    always_comb begin
        own_i_s       = int'(owner_r);
        own_araddr_s  = m_araddr[own_i_s*32 +: 32];
        own_arsize_s  = m_arsize[own_i_s*3 +: 3];
        own_awaddr_s  = m_awaddr[own_i_s*32 +: 32];
        own_awsize_s  = m_awsize[own_i_s*3 +: 3];
        own_wdata_s   = m_wdata[own_i_s*DW +: DW];
        own_wstrb_s   = m_wstrb[own_i_s*SW +: SW];
        own_arvalid_s = m_arvalid[owner_r];
        own_rready_s  = m_rready[owner_r];
        own_awvalid_s = m_awvalid[owner_r];
        own_wvalid_s  = m_wvalid[owner_r];
        own_bready_s  = m_bready[owner_r];
    end

    // FSM next state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_next_s = win_rd_s ? RD : WR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD, WR: begin
                if (done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Owner/target latch, channel progress flags and the local write responder
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_r      <= {GW{1'b0}};
            local_r      <= 1'b0;
            rr_ptr_r     <= GW'(NUM_M - 1);
            ar_done_r    <= 1'b0;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
            loc_aw_rdy_r <= 1'b0;
            loc_w_rdy_r  <= 1'b0;
            loc_bvalid_r <= 1'b0;
        end else if (state_r == IDLE) begin
            ar_done_r    <= 1'b0;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
            loc_aw_rdy_r <= 1'b0;
            loc_w_rdy_r  <= 1'b0;
            loc_bvalid_r <= 1'b0;
            if (found_s) begin
                owner_r <= win_s;
                local_r <= win_local_s;
            end
        end else begin
            if (ar_hs_s) ar_done_r <= 1'b1;
            if (aw_hs_s) aw_done_r <= 1'b1;
            if (w_hs_s)  w_done_r  <= 1'b1;
            // one-cycle ready pulse, one cycle after valid is seen
            loc_aw_rdy_r <= local_wr_s & own_awvalid_s & ~aw_done_r & ~loc_aw_rdy_r;
            loc_w_rdy_r  <= local_wr_s & own_wvalid_s & ~w_done_r & ~loc_w_rdy_r;
            if (loc_bvalid_r && own_bready_s) begin
                loc_bvalid_r <= 1'b0;
            end else if (local_wr_s && aw_done_r && w_done_r) begin
                loc_bvalid_r <= 1'b1;
            end
            if (done_s) rr_ptr_r <= owner_r;
        end
    end

    // Route the owner's channels to the latched target; everything else stays quiet
    always_comb begin
        ext_araddr    = 32'h0;
        ext_arsize    = 3'd0;
        ext_arvalid   = 1'b0;
        ext_rready    = 1'b0;
        ext_awaddr    = 32'h0;
        ext_awsize    = 3'd0;
        ext_awvalid   = 1'b0;
        ext_wdata     = {DW{1'b0}};
        ext_wstrb     = {SW{1'b0}};
        ext_wvalid    = 1'b0;
        ext_wlast     = 1'b0;
        ext_bready    = 1'b0;
        loc_araddr    = 32'h0;
        loc_arvalid   = 1'b0;
        loc_rready    = 1'b0;
        sel_arready_s = 1'b0;
        sel_rvalid_s  = 1'b0;
        sel_rdata_s   = {DW{1'b0}};
        sel_rresp_s   = 2'b00;
        sel_awready_s = 1'b0;
        sel_wready_s  = 1'b0;
        sel_bvalid_s  = 1'b0;
        sel_bresp_s   = 2'b00;
        case ({state_r, local_r})
            {RD, 1'b0}: begin
                ext_araddr    = own_araddr_s;
                ext_arsize    = own_arsize_s;
                ext_arvalid   = own_arvalid_s & ~ar_done_r;
                ext_rready    = own_rready_s;
                sel_arready_s = ext_arready & ~ar_done_r;
                sel_rvalid_s  = ext_rvalid;
                sel_rdata_s   = ext_rdata;
                sel_rresp_s   = ext_rresp;
            end
            {RD, 1'b1}: begin
                loc_araddr    = own_araddr_s;
                loc_arvalid   = own_arvalid_s & ~ar_done_r;
                loc_rready    = own_rready_s;
                sel_arready_s = loc_arready & ~ar_done_r;
                sel_rvalid_s  = loc_rvalid;
                sel_rdata_s   = loc_rdata;
                sel_rresp_s   = loc_rresp;
            end
            {WR, 1'b0}: begin
                ext_awaddr    = own_awaddr_s;
                ext_awsize    = own_awsize_s;
                ext_awvalid   = own_awvalid_s & ~aw_done_r;
                ext_wdata     = own_wdata_s;
                ext_wstrb     = own_wstrb_s;
                ext_wvalid    = own_wvalid_s & ~w_done_r;
                ext_wlast     = own_wvalid_s & ~w_done_r;
                ext_bready    = own_bready_s;
                sel_awready_s = ext_awready & ~aw_done_r;
                sel_wready_s  = ext_wready & ~w_done_r;
                sel_bvalid_s  = ext_bvalid;
                sel_bresp_s   = ext_bresp;
            end
            {WR, 1'b1}: begin
                // local region is read-only: absorb the write and answer SLVERR
                sel_awready_s = loc_aw_rdy_r & ~aw_done_r;
                sel_wready_s  = loc_w_rdy_r & ~w_done_r;
                sel_bvalid_s  = loc_bvalid_r;
                sel_bresp_s   = 2'b10;
            end
            default: begin
                sel_bresp_s = 2'b00;
            end
        endcase
    end

    // Fan responses back to the owner only
    always_comb begin
        m_arready = {NUM_M{1'b0}};
        m_rvalid  = {NUM_M{1'b0}};
        m_awready = {NUM_M{1'b0}};
        m_wready  = {NUM_M{1'b0}};
        m_bvalid  = {NUM_M{1'b0}};
        m_rdata   = {(NUM_M*DW){1'b0}};
        m_rresp   = {(NUM_M*2){1'b0}};
        m_bresp   = {(NUM_M*2){1'b0}};
        for (int i = 0; i < NUM_M; i++) begin
            logic own;
            own = (i == own_i_s);
            m_arready[i]         = sel_arready_s & own;
            m_rvalid[i]          = sel_rvalid_s & own;
            m_awready[i]         = sel_awready_s & own;
            m_wready[i]          = sel_wready_s & own;
            m_bvalid[i]          = sel_bvalid_s & own;
            m_rdata[i*DW +: DW]  = sel_rdata_s & {DW{own}};
            m_rresp[i*2 +: 2]    = sel_rresp_s & {2{own}};
            m_bresp[i*2 +: 2]    = sel_bresp_s & {2{own}};
        end
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter with four masters, a reactive external AXI slave
// and a local (CLINT-like) read slave.
module tb_axi_rr_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [127:0] m_araddr = '0, m_awaddr = '0, m_wdata = '0, m_rdata;
    logic [11:0]  m_arsize = '0, m_awsize = '0;
    logic [15:0]  m_wstrb = '0;
    logic [3:0]   m_arvalid = '0, m_rready = '0, m_awvalid = '0, m_wvalid = '0, m_bready = '0;
    logic [3:0]   m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [7:0]   m_rresp, m_bresp;

    logic [3:0]  ext_arid, ext_awid;
    logic [7:0]  ext_arlen, ext_awlen;
    logic [31:0] ext_araddr, ext_awaddr, ext_wdata;
    logic [2:0]  ext_arsize, ext_awsize;
    logic [1:0]  ext_arburst, ext_awburst;
    logic [3:0]  ext_wstrb;
    logic        ext_arvalid, ext_rready, ext_awvalid, ext_wvalid, ext_wlast, ext_bready;
    logic        ext_arready = 1'b1, ext_awready = 1'b1, ext_wready = 1'b1;
    logic [31:0] ext_rdata;
    logic        ext_rvalid, ext_bvalid;
    logic [1:0]  ext_rresp = 2'b00, ext_bresp = 2'b00;

    logic [31:0] loc_araddr, loc_rdata;
    logic        loc_arvalid, loc_rready, loc_rvalid;
    logic        loc_arready = 1'b1;
    logic [1:0]  loc_rresp = 2'b00;

    logic [1:0] grant;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    axi_rr_arbiter #(.NUM_M(4), .DW(32)) dut (
        .clock(clock), .reset(reset),
        .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .ext_arid(ext_arid), .ext_araddr(ext_araddr), .ext_arlen(ext_arlen), .ext_arsize(ext_arsize),
        .ext_arburst(ext_arburst), .ext_arvalid(ext_arvalid), .ext_arready(ext_arready),
        .ext_rdata(ext_rdata), .ext_rresp(ext_rresp), .ext_rvalid(ext_rvalid), .ext_rready(ext_rready),
        .ext_awid(ext_awid), .ext_awaddr(ext_awaddr), .ext_awlen(ext_awlen), .ext_awsize(ext_awsize),
        .ext_awburst(ext_awburst), .ext_awvalid(ext_awvalid), .ext_awready(ext_awready),
        .ext_wdata(ext_wdata), .ext_wstrb(ext_wstrb), .ext_wlast(ext_wlast), .ext_wvalid(ext_wvalid),
        .ext_wready(ext_wready), .ext_bresp(ext_bresp), .ext_bvalid(ext_bvalid), .ext_bready(ext_bready),
        .loc_araddr(loc_araddr), .loc_arvalid(loc_arvalid), .loc_arready(loc_arready),
        .loc_rdata(loc_rdata), .loc_rresp(loc_rresp), .loc_rvalid(loc_rvalid), .loc_rready(loc_rready),
        .grant(grant), .busy(busy)
    );

    // External slave: one-beat reads numbered E000_0000+n, writes answered OKAY
    int          ext_rd_cnt, ext_aw_cnt, ext_w_cnt;
    logic        aw_got, w_got;
    logic [31:0] awaddr_cap, wdata_cap;
    logic [2:0]  arsize_cap;
    always @(posedge clock) begin
        if (reset) begin
            ext_rvalid <= 1'b0; ext_rdata <= 32'h0; ext_bvalid <= 1'b0;
            aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            if (ext_arvalid && ext_arready) begin
                ext_rvalid <= 1'b1;
                ext_rdata  <= 32'hE000_0000 + ext_rd_cnt;
                ext_rd_cnt <= ext_rd_cnt + 1;
                arsize_cap <= ext_arsize;
            end else if (ext_rvalid && ext_rready) begin
                ext_rvalid <= 1'b0;
            end
            if (ext_awvalid && ext_awready) begin
                aw_got <= 1'b1; ext_aw_cnt <= ext_aw_cnt + 1; awaddr_cap <= ext_awaddr;
            end
            if (ext_wvalid && ext_wready) begin
                w_got <= 1'b1; ext_w_cnt <= ext_w_cnt + 1; wdata_cap <= ext_wdata;
            end
            if (ext_bvalid && ext_bready) begin
                ext_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end else if (aw_got && w_got) begin
                ext_bvalid <= 1'b1;
            end
        end
    end

    // Local slave: returns C11E_xxxx where xxxx is the low address half
    always @(posedge clock) begin
        if (reset) begin
            loc_rvalid <= 1'b0; loc_rdata <= 32'h0;
        end else if (loc_arvalid && loc_arready) begin
            loc_rvalid <= 1'b1; loc_rdata <= {16'hC11E, loc_araddr[15:0]};
        end else if (loc_rvalid && loc_rready) begin
            loc_rvalid <= 1'b0;
        end
    end

    // Monitor: grant order, external-channel activity and response leakage to non-owners
    logic [1:0] grant_log[$];
    logic       busy_prev = 1'b0;
    int         ext_ar_seen = 0, ext_aw_seen = 0, ext_w_seen = 0, leak_cnt = 0;
    always @(negedge clock) begin
        if (reset) busy_prev = 1'b0;
        else begin
            if (busy && !busy_prev) grant_log.push_back(grant);
            busy_prev = busy;
        end
        if (ext_arvalid) ext_ar_seen++;
        if (ext_awvalid) ext_aw_seen++;
        if (ext_wvalid)  ext_w_seen++;
        for (int i = 0; i < 4; i++) begin
            if (!(busy && grant == 2'(i)) &&
                (m_rvalid[i] || m_bvalid[i] || m_arready[i] || m_awready[i] || m_wready[i] ||
                 m_rdata[i*32 +: 32] != 32'h0))
                leak_cnt++;
        end
    end

    task automatic do_read(input int i, input logic [31:0] a, output logic [31:0] d);
        logic got = 1'b0;
        logic ar_hs;
        d = 32'h0;
        m_araddr[i*32 +: 32] = a;
        m_arsize[i*3 +: 3]   = 3'(i % 3);
        m_arvalid[i]         = 1'b1;
        m_rready[i]          = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            ar_hs = m_arvalid[i] && m_arready[i];
            if (m_rvalid[i] && m_rready[i]) begin
                got = 1'b1;
                d   = m_rdata[i*32 +: 32];
            end
            @(posedge clock); #1;
            if (ar_hs) m_arvalid[i] = 1'b0;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL read_timeout m%0d: no R handshake got=%0b want=1", i, got);
            m_arvalid[i] = 1'b0;
        end
    endtask

    task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d,
                            input int lead, output logic [1:0] resp);
        logic got = 1'b0;
        logic aw_hs, w_hs;
        resp = 2'b11;
        m_wdata[i*32 +: 32] = d;
        m_wstrb[i*4 +: 4]   = 4'hF;
        m_wvalid[i]         = 1'b1;
        m_bready[i]         = 1'b1;
        repeat (lead) begin @(posedge clock); #1; end
        m_awaddr[i*32 +: 32] = a;
        m_awsize[i*3 +: 3]   = 3'd2;
        m_awvalid[i]         = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            aw_hs = m_awvalid[i] && m_awready[i];
            w_hs  = m_wvalid[i] && m_wready[i];
            if (m_bvalid[i] && m_bready[i]) begin
                got  = 1'b1;
                resp = m_bresp[i*2 +: 2];
            end
            @(posedge clock); #1;
            if (aw_hs) m_awvalid[i] = 1'b0;
            if (w_hs)  m_wvalid[i]  = 1'b0;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL write_timeout m%0d: no B handshake got=%0b want=1", i, got);
            m_awvalid[i] = 1'b0; m_wvalid[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m_arvalid[0] = 1'b1; m_araddr[31:0] = 32'h8000_0000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_tests++;
        if (busy !== 1'b0 || grant !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: busy=%0b grant=%0d want 0/0", busy, grant);
        end
        n_tests++;
        if (ext_arvalid !== 1'b0 || loc_arvalid !== 1'b0 || m_arready !== 4'h0 || ext_awvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ext_arvalid=%0b loc_arvalid=%0b m_arready=%h want 0", ext_arvalid, loc_arvalid, m_arready);
        end
        @(posedge clock); #1;
        m_arvalid = 4'h0;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_rr_reads();
        logic [31:0] d0[3], d1[3];
        int base = grant_log.size();
        int rbase = ext_rd_cnt;
        for (int r = 0; r < 3; r++) begin
            fork
                do_read(0, 32'h8000_0000, d0[r]);
                do_read(1, 32'h8000_0000, d1[r]);
            join
        end
        n_tests++;
        if (grant_log.size() < base + 3 || grant_log[base] !== 2'd0 || grant_log[base+1] !== 2'd1 || grant_log[base+2] !== 2'd0) begin
            n_fail++; $display("FAIL rr_order: first three grants not 0,1,0 (log size %0d)", grant_log.size() - base);
        end
        n_tests++;
        if (d0[0] !== 32'hE000_0000 + rbase || d1[0] !== 32'hE000_0001 + rbase) begin
            n_fail++; $display("FAIL rr_data0: m0=%h m1=%h want %h/%h", d0[0], d1[0], 32'hE000_0000 + rbase, 32'hE000_0001 + rbase);
        end
        n_tests++;
        if (d0[2] !== 32'hE000_0004 + rbase || d1[2] !== 32'hE000_0005 + rbase) begin
            n_fail++; $display("FAIL rr_data2: m0=%h m1=%h want %h/%h", d0[2], d1[2], 32'hE000_0004 + rbase, 32'hE000_0005 + rbase);
        end
        n_tests++;
        if (arsize_cap !== 3'd1) begin
            n_fail++; $display("FAIL arsize: got %0d want 1", arsize_cap);
        end
    endtask

    task automatic test_local_read();
        logic [31:0] d;
        int ar0 = ext_ar_seen;
        do_read(1, 32'h0200_0048, d);
        n_tests++;
        if (d !== 32'hC11E_0048) begin
            n_fail++; $display("FAIL local_read_data: got %h want C11E0048", d);
        end
        n_tests++;
        if (ext_ar_seen !== ar0) begin
            n_fail++; $display("FAIL local_read_ext_ar: ext_arvalid cycles %0d want 0", ext_ar_seen - ar0);
        end
    endtask

    task automatic test_local_write();
        logic [1:0] resp;
        int aw0 = ext_aw_seen, w0 = ext_w_seen;
        do_write(0, 32'h0200_0000, 32'hDEAD_BEEF, 0, resp);
        n_tests++;
        if (resp !== 2'b10) begin
            n_fail++; $display("FAIL local_write_bresp: got %b want 10", resp);
        end
        n_tests++;
        if (ext_aw_seen !== aw0 || ext_w_seen !== w0) begin
            n_fail++; $display("FAIL local_write_ext: awvalid cycles %0d wvalid cycles %0d want 0/0", ext_aw_seen - aw0, ext_w_seen - w0);
        end
    endtask

    task automatic test_rready_hold();
        logic hs = 1'b0;
        logic seen = 1'b0;
        m_araddr[31:0] = 32'h8000_0100; m_arvalid[0] = 1'b1; m_rready[0] = 1'b0;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge clock); hs = m_arready[0];
            @(posedge clock); #1;
        end
        m_arvalid[0] = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clock); seen = m_rvalid[0];
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL hold_rvalid_timeout: rvalid=%0b want 1", seen);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (busy !== 1'b1 || grant !== 2'd0 || m_rvalid[0] !== 1'b1) begin
                n_fail++; $display("FAIL hold_cycle%0d: busy=%0b grant=%0d rvalid=%0b want 1/0/1", k, busy, grant, m_rvalid[0]);
            end
            @(negedge clock);
        end
        @(posedge clock); #1;
        m_rready[0] = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: busy=%0b want 0", busy);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp;
        int aw0 = ext_aw_cnt, w0 = ext_w_cnt;
        do_write(1, 32'h8000_0010, 32'h1234_5678, 2, resp);
        n_tests++;
        if (resp !== 2'b00) begin
            n_fail++; $display("FAIL wfirst_bresp: got %b want 00", resp);
        end
        n_tests++;
        if (ext_aw_cnt - aw0 !== 1 || ext_w_cnt - w0 !== 1) begin
            n_fail++; $display("FAIL wfirst_count: aw %0d w %0d want 1/1", ext_aw_cnt - aw0, ext_w_cnt - w0);
        end
        n_tests++;
        if (awaddr_cap !== 32'h8000_0010 || wdata_cap !== 32'h1234_5678) begin
            n_fail++; $display("FAIL wfirst_payload: addr %h data %h want 80000010/12345678", awaddr_cap, wdata_cap);
        end
    endtask

    task automatic burst_reads(input int i);
        logic [31:0] d;
        for (int r = 0; r < 3; r++) do_read(i, 32'h8000_0000 + 32'(i * 256), d);
    endtask

    task automatic test_fairness();
        int base = grant_log.size();
        fork
            burst_reads(0); burst_reads(1); burst_reads(2); burst_reads(3);
        join
        n_tests++;
        if (grant_log.size() - base !== 12) begin
            n_fail++; $display("FAIL fair_count: %0d grants want 12", grant_log.size() - base);
        end else begin
            for (int k = 0; k < 11; k++) begin
                n_tests++;
                if (grant_log[base+k+1] !== grant_log[base+k] + 2'd1) begin
                    n_fail++; $display("FAIL fair_step%0d: grant %0d after %0d want %0d", k, grant_log[base+k+1], grant_log[base+k], grant_log[base+k] + 2'd1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d0, d2;
        int base;
        do_read(0, 32'h8000_0200, d0);
        m_araddr[31:0] = 32'h8000_0300; m_arvalid[0] = 1'b1; m_rready[0] = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        m_arvalid = 4'h0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if (busy !== 1'b0 || grant !== 2'd0 || m_rvalid !== 4'h0 || ext_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: busy=%0b grant=%0d m_rvalid=%h ext_arvalid=%0b want 0", busy, grant, m_rvalid, ext_arvalid);
        end
        @(posedge clock); #1;
        base = grant_log.size();
        fork
            do_read(0, 32'h8000_0400, d0);
            do_read(2, 32'h8000_0500, d2);
        join
        n_tests++;
        if (grant_log.size() <= base || grant_log[base] !== 2'd0) begin
            n_fail++; $display("FAIL reset_ptr: first grant after reset not master 0 (log size %0d)", grant_log.size() - base);
        end
    endtask

    task automatic test_isolation();
        n_tests++;
        if (leak_cnt !== 0) begin
            n_fail++; $display("FAIL isolation: %0d non-owner response cycles want 0", leak_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ext_rd_cnt = 0; ext_aw_cnt = 0; ext_w_cnt = 0;
        test_reset();
        test_rr_reads();
        test_local_read();
        test_local_write();
        test_rready_hold();
        test_w_before_aw();
        test_fairness();
        test_reset_mid();
        test_isolation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
